// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Scan controller and arbiter for an 8-digit seven-segment display. The
// persistent base frame is shown by default. A timed overlay frame can take
// over the display for OVL_FRAMES full frames. Overlay switches happen only on
// frame boundaries, and the display then returns to the base frame by itself.
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot
//   BLANK_CYC  dead-time cycles at the start of each slot (seg_en = 0)
//   OVL_FRAMES overlay duration in full 8-slot frames (0 behaves as 1)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   base_wr/addr/data     base frame buffer write port
//   ovl_wr/addr/data      overlay shadow buffer write port
//   ovl_req / ovl_ack     overlay request / one-cycle acceptance pulse
//   ovl_busy              overlay pending or showing
//   blank                 force the display dark (timing keeps running)
//   seg_en                one-hot digit enable
//   tube1 / tube2         segment codes for digits 0-3 / 4-7
//   frame_tick            one-cycle pulse when slot 0 begins
//   state_dbg             current overlay FSM state (debug observation)
//
// Optional feature macro: DISPLAY_OVL_BLINK_EN
//   When defined, the overlay blinks with a phase that toggles every 32 frames.
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000,
  parameter int OVL_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       base_wr,
  input  logic [2:0] base_addr,
  input  logic [7:0] base_data,
  input  logic       ovl_wr,
  input  logic [2:0] ovl_addr,
  input  logic [7:0] ovl_data,
  input  logic       ovl_req,
  output logic       ovl_ack,
  output logic       ovl_busy,
  input  logic       blank,
  output logic [7:0] seg_en,
  output logic [7:0] tube1,
  output logic [7:0] tube2,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_BASE = 2'd0,
    ST_PEND = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);
  localparam logic [15:0]     OVL_LOAD = (OVL_FRAMES == 0) ? 16'd1 : 16'(OVL_FRAMES);

  // Scan counters
  logic [DIV_W-1:0] div_q;
  logic [2:0]       slot_q;
  logic             div_wrap;
  logic             boundary;

  // Buffers: base, shadow and active overlay
  logic [7:0] base_q [8];
  logic [7:0] shd_q  [8];
  logic [7:0] act_q  [8];

  // Overlay control
  state_e      state_q;
  logic [15:0] frm_cnt_q;
  logic        ovl_on_q;   // display source is the active-overlay buffer
  logic        accept;
  logic        blink_dark;

  // Output next-state values
  logic [7:0] seg_en_d;
  logic [7:0] tube1_d;
  logic [7:0] tube2_d;
  logic       frame_tick_d;
  logic [7:0] src;
  logic       dark;

  assign div_wrap  = (div_q == DIV_MAX);
  assign boundary  = div_wrap && (slot_q == 3'd7);
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      slot_q <= 3'd0;
    end else if (div_wrap) begin
      div_q  <= '0;
      slot_q <= slot_q + 3'd1;
    end else begin
      div_q  <= div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Buffers. The boundary copy reads shd_q before any same-cycle shadow write
  // lands, so a colliding write only affects the next overlay.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        base_q[i] <= 8'h00;
        shd_q[i]  <= 8'h00;
        act_q[i]  <= 8'h00;
      end
    end else begin
      if (base_wr) base_q[base_addr] <= base_data;
      if (ovl_wr)  shd_q[ovl_addr]   <= ovl_data;
      if (state_q == ST_PEND && boundary) begin
        for (int i = 0; i < 8; i++) act_q[i] <= shd_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overlay FSM.
  // Handshake: ovl_req is a level sampled every cycle; it is accepted only in
  // BASE or SHOW, and acceptance is signalled by ovl_ack high for exactly the
  // following cycle. Requests seen while PEND are dropped without an ack.
  // ---------------------------------------------------------------------------
  assign accept = ovl_req && (state_q == ST_BASE || state_q == ST_SHOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BASE;
      frm_cnt_q <= 16'd0;
      ovl_on_q  <= 1'b0;
      ovl_ack   <= 1'b0;
      ovl_busy  <= 1'b0;
    end else begin
      ovl_ack  <= accept;
      // Set together with ack; afterwards it follows the state with one cycle
      // of lag so the fall lines up with the first base slot-0 output.
      ovl_busy <= accept || (state_q != ST_BASE);
      case (state_q)
        ST_BASE: begin
          if (ovl_req) state_q <= ST_PEND;
        end
        ST_PEND: begin
          if (boundary) begin
            state_q   <= ST_SHOW;
            frm_cnt_q <= OVL_LOAD;
            ovl_on_q  <= 1'b1;
          end
        end
        ST_SHOW: begin
          // A retrigger keeps the old overlay visible until the next boundary,
          // unless the old overlay's timer expires on this very boundary.
          if (ovl_req) state_q <= ST_PEND;
          if (boundary) begin
            if (frm_cnt_q == 16'd1) begin
              ovl_on_q <= 1'b0;
              if (!ovl_req) state_q <= ST_BASE;
            end else begin
              frm_cnt_q <= frm_cnt_q - 16'd1;
            end
          end
        end
        default: begin
          state_q  <= ST_BASE;
          ovl_on_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional overlay blink
  // ---------------------------------------------------------------------------
`ifdef DISPLAY_OVL_BLINK_EN
  logic [4:0] blink_cnt_q;
  logic       blink_off_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= 5'd0;
      blink_off_q <= 1'b0;
    end else if (state_q == ST_PEND && boundary) begin
      blink_cnt_q <= 5'd0;
      blink_off_q <= 1'b0;
    end else if (ovl_on_q && boundary) begin
      blink_cnt_q <= blink_cnt_q + 5'd1;
      if (blink_cnt_q == 5'd31) blink_off_q <= ~blink_off_q;
    end
  end

  assign blink_dark = ovl_on_q && blink_off_q;
`else
  assign blink_dark = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output generation, registered below
  // ---------------------------------------------------------------------------
  always_comb begin
    src          = ovl_on_q ? act_q[slot_q] : base_q[slot_q];
    dark         = blank || blink_dark;
    seg_en_d     = 8'h00;
    tube1_d      = 8'h00;
    tube2_d      = 8'h00;
    frame_tick_d = (div_q == '0) && (slot_q == 3'd0);
    if (!dark && (div_q >= BLANK_V)) seg_en_d = 8'h01 << slot_q;
    if (!dark && !slot_q[2]) tube1_d = src;
    if (!dark &&  slot_q[2]) tube2_d = src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en     <= 8'h00;
      tube1      <= 8'h00;
      tube2      <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      seg_en     <= seg_en_d;
      tube1      <= tube1_d;
      tube2      <= tube2_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Drives directed scenarios followed by random traffic into display_scheduler
// (SCAN_DIV=10, BLANK_CYC=2, OVL_FRAMES=3) and compares every output, every
// cycle, against a position-based reference model. The model describes the
// display as a timeline: a cycle position since reset, and an overlay time
// window [sh_from, sh_to) during which the overlay content is shown.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

  localparam int SD = 10;
  localparam int BC = 2;
  localparam int OF = 3;
  localparam int FR = 8 * SD;

  logic       clk;
  logic       rst;
  logic       base_wr;
  logic [2:0] base_addr;
  logic [7:0] base_data;
  logic       ovl_wr;
  logic [2:0] ovl_addr;
  logic [7:0] ovl_data;
  logic       ovl_req;
  logic       ovl_ack;
  logic       ovl_busy;
  logic       blank;
  logic [7:0] seg_en;
  logic [7:0] tube1;
  logic [7:0] tube2;
  logic       frame_tick;
  logic [1:0] state_dbg;

  display_scheduler #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC),
    .OVL_FRAMES(OF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .base_wr   (base_wr),
    .base_addr (base_addr),
    .base_data (base_data),
    .ovl_wr    (ovl_wr),
    .ovl_addr  (ovl_addr),
    .ovl_data  (ovl_data),
    .ovl_req   (ovl_req),
    .ovl_ack   (ovl_ack),
    .ovl_busy  (ovl_busy),
    .blank     (blank),
    .seg_en    (seg_en),
    .tube1     (tube1),
    .tube2     (tube2),
    .frame_tick(frame_tick),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Position q is the scan position whose output appears after
  // a given clock edge: digit slot (q/SD)%8, offset q%SD, frame start q%FR==0.
  // ---------------------------------------------------------------------------
  logic [26:0] exp_q[$];
  int          p;
  int          sh_from;
  int          sh_to;
  bit          pend_m;
  logic [7:0]  base_m [8];
  logic [7:0]  shd_m  [8];
  logic [7:0]  act_m  [8];

  always @(posedge clk) begin
    int         q;
    int         dv;
    int         sl;
    bit         pb;
    bit         acc;
    bit         inr;
    logic [7:0] src;
    logic [7:0] seg;
    logic [7:0] t1;
    logic [7:0] t2;
    if (rst) begin
      p       = 0;
      pend_m  = 1'b0;
      sh_from = 0;
      sh_to   = 0;
      for (int i = 0; i < 8; i++) begin
        base_m[i] = 8'h00;
        shd_m[i]  = 8'h00;
        act_m[i]  = 8'h00;
      end
      exp_q.push_back(27'd0);
    end else begin
      p++;
      q   = p - 1;
      dv  = q % SD;
      sl  = (q / SD) % 8;
      pb  = pend_m;
      acc = ovl_req && !pb;
      inr = (q >= sh_from) && (q < sh_to);
      src = inr ? act_m[sl] : base_m[sl];
      seg = (blank || dv < BC) ? 8'h00 : 8'(1 << sl);
      t1  = (blank || sl >= 4) ? 8'h00 : src;
      t2  = (blank || sl < 4)  ? 8'h00 : src;
      exp_q.push_back({seg, t1, t2, (q % FR == 0), acc, (pb || acc || inr)});
      // A pending overlay starts on the next frame start and lasts OF frames,
      // with the shadow contents as they were before this edge's writes.
      if ((q % FR == FR - 1) && pb) begin
        for (int i = 0; i < 8; i++) act_m[i] = shd_m[i];
        sh_from = q + 1;
        sh_to   = q + 1 + OF * FR;
        pend_m  = 1'b0;
      end
      if (acc) pend_m = 1'b1;
      if (base_wr) base_m[base_addr] = base_data;
      if (ovl_wr)  shd_m[ovl_addr]   = ovl_data;
    end
  end

  // Scoreboard: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [26:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg_en",     32'(seg_en),     32'(e[26:19]));
      check("tube1",      32'(tube1),      32'(e[18:11]));
      check("tube2",      32'(tube2),      32'(e[10:3]));
      check("frame_tick", 32'(frame_tick), 32'(e[2]));
      check("ovl_ack",    32'(ovl_ack),    32'(e[1]));
      check("ovl_busy",   32'(ovl_busy),   32'(e[0]));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    base_wr = 1'b0;
    ovl_wr  = 1'b0;
    ovl_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_base(input logic [2:0] a, input logic [7:0] d);
    base_wr = 1'b1; base_addr = a; base_data = d;
    step();
  endtask

  task automatic wr_shd(input logic [2:0] a, input logic [7:0] d);
    ovl_wr = 1'b1; ovl_addr = a; ovl_data = d;
    step();
  endtask

  task automatic fill_shd(input logic [7:0] d);
    for (int k = 0; k < 8; k++) wr_shd(3'(k), d);
  endtask

  task automatic req_pulse();
    ovl_req = 1'b1;
    step();
  endtask

  // Advance until the next edge samples scan slot s.
  task automatic wait_slot(input int s);
    int n = 0;
    while (((p / SD) % 8) != s && n < 2 * FR) begin
      step();
      n++;
    end
    if (n >= 2 * FR) check("wait_slot_timeout", 32'd1, 32'd0);
  endtask

  // Advance until the next edge is a frame boundary.
  task automatic wait_boundary();
    int n = 0;
    while ((p % FR) != FR - 1 && n < 2 * FR) begin
      step();
      n++;
    end
    if (n >= 2 * FR) check("wait_boundary_timeout", 32'd1, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; blank = 1'b0;
    base_wr = 1'b0; base_addr = 3'd0; base_data = 8'h00;
    ovl_wr = 1'b0;  ovl_addr = 3'd0;  ovl_data = 8'h00;
    ovl_req = 1'b0;
    idle(3);
    rst = 1'b0;

    // Base scan with one-hot digit codes
    for (int k = 0; k < 8; k++) wr_base(3'(k), 8'(1 << k));
    idle(2 * FR);

    // Overlay requested in slot 3
    fill_shd(8'hAA);
    wait_slot(3);
    req_pulse();
    idle(5 * FR);

    // Retrigger during the second overlay frame, then a dropped request in PEND
    fill_shd(8'hAA);
    req_pulse();
    wait_boundary();
    idle(FR + 20);
    fill_shd(8'h55);
    req_pulse();
    idle(5);
    req_pulse();
    idle(5 * FR);

    // Shadow write colliding with the boundary copy
    fill_shd(8'h11);
    req_pulse();
    wait_boundary();
    wr_shd(3'd0, 8'hFF);
    idle(4 * FR);

    // Reset in the middle of an overlay
    req_pulse();
    idle(FR + 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(FR + 5);

    // Blank held across a full overlay
    for (int k = 0; k < 8; k++) wr_base(3'(k), 8'($urandom));
    fill_shd(8'h3C);
    req_pulse();
    blank = 1'b1;
    idle(5 * FR);
    blank = 1'b0;
    idle(FR);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      base_wr   = ($urandom_range(0, 7) == 0);
      base_addr = 3'($urandom_range(0, 7));
      base_data = 8'($urandom);
      ovl_wr    = ($urandom_range(0, 7) == 0);
      ovl_addr  = 3'($urandom_range(0, 7));
      ovl_data  = 8'($urandom);
      ovl_req   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) blank = ~blank;
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst   = 1'b0;
    blank = 1'b0;
    idle(2 * FR);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-multiplexed scan controller and arbiter for the 8-digit seven-segment display. It owns the digit scan and drives `seg_en`, `tube1` (digits 0-3) and `tube2` (digits 4-7). It shares the display between a persistent base frame, written by the mode/menu logic, and a timed overlay frame for short messages such as ratings or song numbers. Overlay switches happen only on frame boundaries and are followed by an automatic return to the base frame.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz).
- `BLANK_CYC`, default 1000: dead-time cycles at the start of each slot, with `seg_en` = 0. Legal range is 0 to `SCAN_DIV`-1.
- `OVL_FRAMES`, default 250: overlay duration in full 8-slot frames. Range 1..65535; 0 is treated as 1.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `base_wr` in 1: write strobe for the base frame buffer.
- `base_addr` in 3: digit index 0-7 for base writes.
- `base_data` in 8: segment code for base writes.
- `ovl_wr` in 1: write strobe for the overlay shadow buffer.
- `ovl_addr` in 3: digit index 0-7 for overlay shadow writes.
- `ovl_data` in 8: segment code for overlay shadow writes.
- `ovl_req` in 1: request to show the shadow buffer as an overlay.
- `ovl_ack` out 1: one-cycle acceptance pulse for `ovl_req`.
- `ovl_busy` out 1: high while an overlay is pending or showing.
- `blank` in 1: force the display dark.
- `seg_en` out 8: one-hot digit enable; bit k selects digit k.
- `tube1` out 8: segment code for digits 0-3.
- `tube2` out 8: segment code for digits 4-7.
- `frame_tick` out 1: one-cycle pulse when slot 0 begins.

## Operation
- Three buffers, each 8 x 8 bit: base, shadow and active-overlay. All are cleared to 8'h00 (the empty code) on reset.
- Scan:
  - `div` counts 0..`SCAN_DIV`-1.
  - `slot` (3 bit) increments when `div` wraps; 7 wraps to 0.
  - Frame boundary: the cycle with `div`=`SCAN_DIV`-1 and `slot`=7.
- Display source: the active-overlay buffer in state SHOW, otherwise the base buffer.
- Per-slot output:
  - When `div` < `BLANK_CYC`: `seg_en`=0.
  - Otherwise: `seg_en`=1<<`slot`.
  - `tube1` = source[`slot`] when `slot`<4, else 8'h00.
  - `tube2` = source[`slot`] when `slot`>=4, else 8'h00.
- `blank`=1: `seg_en`=0 and both tubes 8'h00. Counters, the FSM and the overlay timer keep running.
- FSM states:
  - BASE: `ovl_req` → `ovl_ack`, go to PEND.
  - PEND: at the frame boundary, copy shadow → active, load `frm_cnt`=`OVL_FRAMES`, go to SHOW. `ovl_req` in PEND is ignored (no ack).
  - SHOW, on each frame boundary:
    - If `frm_cnt`=1, go to BASE.
    - Otherwise decrement `frm_cnt`.
  - SHOW retrigger: `ovl_req` → `ovl_ack`, go to PEND. The old overlay keeps showing until the next boundary, which reloads content and timer.
- `ovl_busy` = (state != BASE).
- Buffer write rules:
  - Writes take effect on the next clock.
  - Base writes are visible immediately, including mid-frame.
  - Shadow writes never alter the active-overlay buffer directly.
  - When a shadow write and a boundary copy occur in the same cycle, the copy takes the pre-write shadow value.
- `frm_cnt` is 16 bit.

## Timing
- All outputs are registered. Outputs reflect counter and FSM state with 1-cycle latency.
- Reset values:
  - Outputs: `seg_en`=0, `tube1`=`tube2`=8'h00, `ovl_ack`=0, `ovl_busy`=0, `frame_tick`=0.
  - Internal: `div`=0, `slot`=0, state=BASE.
- Reset asserted mid-overlay: the overlay is abandoned and all buffers are cleared. Outputs take reset values on the clock after `rst` is sampled high.
- `ovl_ack` is high for exactly one cycle, the cycle after the accepted `ovl_req` is sampled.
- `ovl_busy` rises together with `ovl_ack`.
- The overlay's first slot-0 output and `frame_tick` appear in the same cycle.
- Return to base: the first slot-0 output of base content coincides with `frame_tick`, `OVL_FRAMES` frames after the overlay started. `ovl_busy` falls in that same cycle.
- A frame lasts 8·`SCAN_DIV` cycles. `frame_tick` fires every frame, including while `blank` is high.

## Configuration
- `DISPLAY_OVL_BLINK_EN` defined:
  - While in SHOW, the overlay blinks.
  - A 5-bit frame counter, reset at SHOW entry, toggles a phase bit every 32 frames.
  - During the off-phase, `seg_en`=0 and both tubes are 8'h00.
  - Timing of the return to BASE is unchanged.
- `DISPLAY_OVL_BLINK_EN` undefined: the overlay is shown steadily. No blink logic is generated.

## Test plan
Bench parameters: `SCAN_DIV`=10, `BLANK_CYC`=2, `OVL_FRAMES`=3.
- Base scan: after reset, write base[k]=1<<k for k=0..7 → for each slot, `seg_en`=0 for 2 cycles and then 1<<k for 8 cycles. `tube1`=1<<k for k<4, `tube2`=1<<k for k>=4, the other tube 8'h00. `frame_tick` every 80 cycles.
- Overlay: fill shadow with 8'hAA and pulse `ovl_req` in slot 3 → `ovl_ack` one cycle later and `ovl_busy`=1. Base content continues until the next `frame_tick`, then tubes show 8'hAA for 240 cycles, then base returns with `ovl_busy`=0.
- Retrigger: during the 2nd overlay frame, write shadow to 8'h55 and pulse `ovl_req` → `ovl_ack` pulses. 8'h55 appears at the next boundary and lasts a fresh 3 frames. Repeat the pulse in PEND → no `ovl_ack`.
- Boundary collision: `ovl_wr` to digit 0 with 8'hFF in the PEND boundary cycle → overlay digit 0 shows the old shadow value, not 8'hFF.
- Reset mid-overlay: assert `rst` during SHOW → next cycle all outputs are 0 and state is BASE. After release, the scan restarts at slot 0 with blank (8'h00) digits.
- Blank: hold `blank`=1 across a full overlay → `seg_en` stays 0 and `frame_tick` still pulses. After release, base content shows and `ovl_busy`=0.
